// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame layout and
// common command/response bytes used by the host TX and scan-code RX paths.
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE      = 3'd0;
    localparam ps2_state_t ST_INHIBIT   = 3'd1;
    localparam ps2_state_t ST_REQUEST   = 3'd2;
    localparam ps2_state_t ST_SHIFT     = 3'd3;
    localparam ps2_state_t ST_ACK       = 3'd4;
    localparam ps2_state_t ST_WAIT_IDLE = 3'd5;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;
    localparam logic PS2_ACK_BIT   = 1'b0;

    localparam logic [7:0] PS2_CMD_SET_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND    = 8'hFE;

    localparam int PS2_FRAME_BITS = 10;
    localparam int PS2_CNT_W      = 20;

    typedef logic [PS2_FRAME_BITS-1:0] ps2_frame_t;

    // Stop bit, odd parity, data; the start bit is driven separately before the first fall.
    function automatic ps2_frame_t ps2MakeFrame(input logic [7:0] data);
        return {PS2_STOP_BIT, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, with a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iPs2Clk,
    input  logic iPs2Data,
    output logic oClk,
    output logic oData,
    output logic oClkFall
);

    logic [1:0] clkSync;
    logic [1:0] dataSync;
    logic       clkPrev;

    // NOTE: reset to the idle-high bus level so leaving reset never fakes a fall.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], iPs2Clk};
            dataSync <= {dataSync[0], iPs2Data};
            clkPrev  <= clkSync[1];
        end
    end

    assign oClk     = clkSync[1];
    assign oData    = dataSync[1];
    assign oClkFall = clkPrev & ~clkSync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked
// shift-out of one byte, device ACK check, and a watchdog over the device phase.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned REQUEST_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES = 850000
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iSend,
    input  logic [7:0] iData,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPs2ClkOe,
    output logic       oPs2DataOe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] REQUEST_LAST = PS2_CNT_W'(REQUEST_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] TIMEOUT_LAST = PS2_CNT_W'(TIMEOUT_CYCLES - 1);

    logic clkSync;
    logic dataSync;
    logic clkFall;

    ps2_line_sync uSync (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iPs2Clk  (iPs2Clk),
        .iPs2Data (iPs2Data),
        .oClk     (clkSync),
        .oData    (dataSync),
        .oClkFall (clkFall)
    );

    ps2_state_t           state;
    logic [PS2_CNT_W-1:0] cnt;
    logic [3:0]           bitCnt;
    ps2_frame_t           frame;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitCnt <= '0;
            frame  <= '1;
            oDone  <= 1'b0;
            oError <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iSend) begin
                        frame  <= ps2MakeFrame(iData);
                        cnt    <= '0;
                        bitCnt <= '0;
                        state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_REQUEST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (cnt == REQUEST_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Device-clocked phase: the watchdog wins over a coincident fall.
                    if (cnt == TIMEOUT_LAST) begin
                        oError <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        case (state)
                            ST_SHIFT: begin
                                if (clkFall) begin
                                    bitCnt <= bitCnt + 4'd1;
                                    // Fall 1 replaces the start bit with data bit 0 already in frame[0].
                                    if (bitCnt != 4'd0) frame <= {PS2_STOP_BIT, frame[PS2_FRAME_BITS-1:1]};
                                    if (bitCnt == 4'd9) state <= ST_ACK;
                                end
                            end
                            ST_ACK: begin
                                if (clkFall) begin
                                    bitCnt <= bitCnt + 4'd1;
                                    if (dataSync == PS2_ACK_BIT) begin
                                        state <= ST_WAIT_IDLE;
                                    end else begin
                                        oError <= 1'b1;
                                        state  <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clkSync && dataSync) begin
                                    oDone <= 1'b1;
                                    state <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // NOTE: defaults first so no state leaves an enable unassigned (no latch).
    always_comb begin
        oPs2ClkOe  = 1'b0;
        oPs2DataOe = 1'b0;
        case (state)
            ST_INHIBIT: oPs2ClkOe = 1'b1;
            ST_REQUEST: begin
                oPs2ClkOe  = 1'b1;
                oPs2DataOe = ~PS2_START_BIT;
            end
            ST_SHIFT:   oPs2DataOe = (bitCnt == 4'd0) ? ~PS2_START_BIT : ~frame[0];
            default:    ;
        endcase
    end

    assign oBusy = (state != ST_IDLE);

endmodule
